// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with an exact occupancy count, threshold flags,
// a selectable registered / first-word-fall-through read port, and sticky
// overflow/underflow error flags.
module sync_fifo_ctl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PTR        = 4,
    parameter int unsigned AFULL_LVL  = 12,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter bit          FWFT       = 1'b0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dataout,
    output logic             wrfull,
    output logic             rdfull,
    output logic             wrempty,
    output logic             rdempty,
    output logic [PTR:0]     usedw,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf,
    output logic             udf
);

    // Reject inconsistent parameter sets at elaboration time.
    if (DEPTH != (32'd1 << PTR)) begin : g_bad_depth
        $error("sync_fifo_ctl: DEPTH must equal 2**PTR");
    end
    if (DEPTH < 4) begin : g_small_depth
        $error("sync_fifo_ctl: DEPTH must be at least 4");
    end
    if (AEMPTY_LVL >= AFULL_LVL) begin : g_bad_lvl
        $error("sync_fifo_ctl: AEMPTY_LVL must be below AFULL_LVL");
    end
    if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
        $error("sync_fifo_ctl: AFULL_LVL must be in 1..DEPTH");
    end

    localparam logic [PTR:0]   CNT_FULL   = (PTR + 1)'(DEPTH);
    localparam logic [PTR:0]   CNT_AFULL  = (PTR + 1)'(AFULL_LVL);
    localparam logic [PTR:0]   CNT_AEMPTY = (PTR + 1)'(AEMPTY_LVL);
    localparam logic [PTR:0]   CNT_ONE    = (PTR + 1)'(1);
    localparam logic [PTR-1:0] PTR_ONE    = PTR'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR:0]   usedw_q, usedw_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic           rd_acc, wr_acc;

    // Accept decisions; a write into a full FIFO rides on a same-cycle read.
    always_comb begin
        rd_acc = rden & (usedw_q != '0);
        wr_acc = wren & ((usedw_q != CNT_FULL) | rd_acc);
    end

    // Pointer, occupancy and sticky error next-state; a set beats clr_err.
    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        usedw_d  = usedw_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + CNT_ONE;
            2'b01:   usedw_d = usedw_q - CNT_ONE;
            default: usedw_d = usedw_q;
        endcase
        ovf_d = (ovf_q & ~clr_err) | (wren & ~wr_acc);
        udf_d = (udf_q & ~clr_err) | (rden & ~rd_acc);
    end

    // Control state; reset discards all stored words immediately.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word falls straight through; meaningless while empty.
        always_comb begin
            dataout = mem_q[rd_ptr_q];
        end
    end else begin : g_reg
        logic [WIDTH-1:0] dataout_q, dataout_d;

        // Registered read port holds its value unless a read is accepted.
        always_comb begin
            dataout_d = rd_acc ? mem_q[rd_ptr_q] : dataout_q;
        end

        // Read data register.
        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                dataout_q <= '0;
            end else begin
                dataout_q <= dataout_d;
            end
        end

        always_comb begin
            dataout = dataout_q;
        end
    end

    // Status flags decode only the registered occupancy.
    always_comb begin
        usedw        = usedw_q;
        wrfull       = (usedw_q == CNT_FULL);
        rdfull       = (usedw_q == CNT_FULL);
        wrempty      = (usedw_q == '0);
        rdempty      = (usedw_q == '0);
        almost_full  = (usedw_q >= CNT_AFULL);
        almost_empty = (usedw_q <= CNT_AEMPTY);
        ovf          = ovf_q;
        udf          = udf_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: a registered-read instance and an FWFT
// instance share one stimulus stream.
module tb_sync_fifo_ctl;

    logic       clk;
    logic       reset_;
    logic       wren;
    logic [7:0] datain;
    logic       rden;
    logic       clr_err;

    logic [7:0] r_dout, f_dout;
    logic       r_wrfull, r_rdfull, r_wrempty, r_rdempty, r_af, r_ae, r_ovf, r_udf;
    logic       f_wrfull, f_rdfull, f_wrempty, f_rdempty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] r_usedw, f_usedw;

    int errors = 0;
    int checks = 0;

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(16), .PTR(4), .AFULL_LVL(12), .AEMPTY_LVL(2),
                    .FWFT(1'b0)) dut_reg (
        .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .rden(rden),
        .clr_err(clr_err), .dataout(r_dout), .wrfull(r_wrfull), .rdfull(r_rdfull),
        .wrempty(r_wrempty), .rdempty(r_rdempty), .usedw(r_usedw),
        .almost_full(r_af), .almost_empty(r_ae), .ovf(r_ovf), .udf(r_udf)
    );

    sync_fifo_ctl #(.WIDTH(8), .DEPTH(16), .PTR(4), .AFULL_LVL(12), .AEMPTY_LVL(2),
                    .FWFT(1'b1)) dut_fwft (
        .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .rden(rden),
        .clr_err(clr_err), .dataout(f_dout), .wrfull(f_wrfull), .rdfull(f_rdfull),
        .wrempty(f_wrempty), .rdempty(f_rdempty), .usedw(f_usedw),
        .almost_full(f_af), .almost_empty(f_ae), .ovf(f_ovf), .udf(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren = 1'b0; rden = 1'b0; clr_err = 1'b0; datain = 8'h00;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        idle();
        tick(); tick();
        checks++; if (r_usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw got %0d exp 0", r_usedw); end
        checks++; if (r_dout !== 8'h00) begin errors++; $display("FAIL reset_dataout got %h exp 00", r_dout); end
        checks++; if ({r_wrempty, r_rdempty, r_wrfull, r_rdfull} !== 4'b1100) begin errors++; $display("FAIL reset_emptyfull got %b exp 1100", {r_wrempty, r_rdempty, r_wrfull, r_rdfull}); end
        checks++; if ({r_ae, r_af, r_ovf, r_udf} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp 1000", {r_ae, r_af, r_ovf, r_udf}); end
        checks++; if ({f_usedw, f_rdempty, f_ovf, f_udf} !== {5'd0, 3'b100}) begin errors++; $display("FAIL reset_fwft got %b exp 00000100", {f_usedw, f_rdempty, f_ovf, f_udf}); end
        reset_ = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1; datain = 8'(8'hE0 + i);
            tick();
        end
        idle();
        checks++; if (r_usedw !== 5'd3) begin errors++; $display("FAIL areset_pre got %0d exp 3", r_usedw); end
        #2 reset_ = 1'b0;
        #1;
        checks++; if (r_usedw !== 5'd0 || r_rdempty !== 1'b1) begin errors++; $display("FAIL areset_noedge got usedw=%0d empty=%b exp 0/1", r_usedw, r_rdempty); end
        reset_ = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            wren = 1'b1; datain = 8'(i);
            tick();
            checks++; if (r_usedw !== 5'(i) || r_af !== (i >= 12)) begin errors++; $display("FAIL fill_%0d got usedw=%0d af=%b exp %0d/%b", i, r_usedw, r_af, i, (i >= 12)); end
        end
        checks++; if ({r_wrfull, r_rdfull} !== 2'b11) begin errors++; $display("FAIL full_flags got %b exp 11", {r_wrfull, r_rdfull}); end
        datain = 8'h11;
        tick();
        idle();
        checks++; if (r_ovf !== 1'b1 || r_usedw !== 5'd16) begin errors++; $display("FAIL overflow got ovf=%b usedw=%0d exp 1/16", r_ovf, r_usedw); end
        checks++; if (r_udf !== 1'b0) begin errors++; $display("FAIL overflow_udf got %b exp 0", r_udf); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (r_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", r_ovf); end
        for (int i = 1; i <= 16; i++) begin
            rden = 1'b1;
            tick();
            checks++; if (r_dout !== 8'(i)) begin errors++; $display("FAIL drain_data_%0d got %h exp %h", i, r_dout, 8'(i)); end
            checks++; if (r_usedw !== 5'(16 - i) || r_ae !== ((16 - i) <= 2)) begin errors++; $display("FAIL drain_cnt_%0d got usedw=%0d ae=%b exp %0d/%b", i, r_usedw, r_ae, 16 - i, ((16 - i) <= 2)); end
        end
        idle();
        checks++; if (r_rdempty !== 1'b1 || r_udf !== 1'b0) begin errors++; $display("FAIL drain_end got empty=%b udf=%b exp 1/0", r_rdempty, r_udf); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; datain = 8'(8'h20 + i);
            tick();
        end
        wren = 1'b1; rden = 1'b1; datain = 8'hAA;
        tick();
        idle();
        checks++; if (r_usedw !== 5'd16 || r_ovf !== 1'b0) begin errors++; $display("FAIL full_rw got usedw=%0d ovf=%b exp 16/0", r_usedw, r_ovf); end
        checks++; if (r_dout !== 8'h20) begin errors++; $display("FAIL full_rw_head got %h exp 20", r_dout); end
        for (int i = 0; i < 16; i++) begin
            rden = 1'b1;
            tick();
        end
        idle();
        checks++; if (r_dout !== 8'hAA || r_usedw !== 5'd0) begin errors++; $display("FAIL full_rw_last got %h usedw=%0d exp AA/0", r_dout, r_usedw); end
    endtask

    task automatic test_empty_rw();
        wren = 1'b1; rden = 1'b1; datain = 8'h55;
        tick();
        idle();
        checks++; if (r_udf !== 1'b1 || r_usedw !== 5'd1) begin errors++; $display("FAIL empty_rw got udf=%b usedw=%0d exp 1/1", r_udf, r_usedw); end
        checks++; if (r_dout !== 8'hAA) begin errors++; $display("FAIL empty_rw_hold got %h exp AA", r_dout); end
        clr_err = 1'b1;
        tick();
        idle();
        checks++; if (r_udf !== 1'b0 || r_usedw !== 5'd1) begin errors++; $display("FAIL udf_clear got udf=%b usedw=%0d exp 0/1", r_udf, r_usedw); end
        rden = 1'b1;
        tick();
        idle();
        checks++; if (r_dout !== 8'h55 || r_usedw !== 5'd0) begin errors++; $display("FAIL empty_rw_read got %h usedw=%0d exp 55/0", r_dout, r_usedw); end
        // Underflow set and clear on the same edge: the set wins.
        rden = 1'b1; clr_err = 1'b1;
        tick();
        idle();
        checks++; if (r_udf !== 1'b1) begin errors++; $display("FAIL udf_set_wins got %b exp 1", r_udf); end
        clr_err = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_fwft();
        wren = 1'b1; datain = 8'h3C;
        tick();
        idle();
        checks++; if (f_dout !== 8'h3C || f_rdempty !== 1'b0) begin errors++; $display("FAIL fwft_fall got %h empty=%b exp 3C/0", f_dout, f_rdempty); end
        checks++; if (r_dout !== 8'h55) begin errors++; $display("FAIL reg_latency got %h exp 55", r_dout); end
        rden = 1'b1;
        tick();
        idle();
        checks++; if (f_usedw !== 5'd0 || f_udf !== 1'b0) begin errors++; $display("FAIL fwft_pop got usedw=%0d udf=%b exp 0/0", f_usedw, f_udf); end
        checks++; if (r_dout !== 8'h3C) begin errors++; $display("FAIL reg_after_pop got %h exp 3C", r_dout); end
    endtask

    task automatic test_back_to_back();
        clr_err = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1; datain = 8'(8'h80 + i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            wren = 1'b1; rden = 1'b1; datain = 8'(8'h85 + k);
            tick();
            checks++; if (r_dout !== 8'(8'h80 + k) || r_usedw !== 5'd5) begin errors++; $display("FAIL wrap_reg_%0d got %h usedw=%0d exp %h/5", k, r_dout, r_usedw, 8'(8'h80 + k)); end
            checks++; if (f_dout !== 8'(8'h81 + k)) begin errors++; $display("FAIL wrap_fwft_%0d got %h exp %h", k, f_dout, 8'(8'h81 + k)); end
        end
        idle();
        checks++; if ({r_ovf, r_udf, f_ovf, f_udf} !== 4'b0000) begin errors++; $display("FAIL wrap_errs got %b exp 0000", {r_ovf, r_udf, f_ovf, f_udf}); end
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        test_reset();
        test_async_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
